// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch stage: PC register, req/ack fetch FSM, next-PC selection
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic        commit,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b01;
    localparam logic [1:0] OP_PC4    = 2'b10;
    localparam logic [1:0] OP_JAL    = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic [31:0] npc;
    logic        npc_misaligned;
    logic        fetch_done;
    logic        issue_done;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc_plus_imm = pc_q + imm;
    assign jalr_sum    = rs1_data + imm;

    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            OP_BRANCH: npc = br_taken ? pc_plus_imm : pc_plus4;
            OP_JALR:   npc = jalr_sum & 32'hFFFF_FFFE;
            OP_PC4:    npc = pc_plus4;
            OP_JAL:    npc = pc_plus_imm;
            default:   npc = pc_plus4;
        endcase
    end

    // jalr clears bit 0 only, so bit 1 can still leave a halfword-aligned target
    assign npc_misaligned = (npc[1:0] != 2'b00);
    assign fetch_done     = (state == S_FETCH) && imem_ack;
    assign issue_done     = (state == S_ISSUE) && commit;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_ISSUE;
            S_ISSUE: if (commit)   state_nxt = npc_misaligned ? S_ERR : S_FETCH;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
        end else begin
            if (fetch_done) begin
                inst_q <= imem_rdata;
            end
            if (issue_done) begin
                inst_q <= NOP_INST;
                if (!npc_misaligned) begin
                    pc_q <= npc;
                end
            end
        end
    end

    // All handshake/status outputs come from registered state, never from inputs
    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state == S_ISSUE);
    assign fetch_err  = (state == S_ERR);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc4        = pc_plus4;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        commit = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic        fetch_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    typedef struct packed {
        logic [1:0]  op;
        logic        bt;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rdata;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t tbl [12];

    ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .commit     (commit),
        .npc_op     (npc_op),
        .br_taken   (br_taken),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic bt,
                                            input logic [31:0] p, input logic [31:0] im,
                                            input logic [31:0] r);
        logic [31:0] s;
        s = r + im;
        case (op)
            2'd0:    return bt ? p + im : p + 32'd4;
            2'd1:    return s - (s % 2);
            2'd2:    return p + 32'd4;
            default: return p + im;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        commit = 1'b0;
        repeat (3) step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, NOP_INST);
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        chk("idle_req", imem_req, 1'b0);
    endtask

    task automatic instr(input vec_t v, input int nwait, input int hold, input bit spur);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_invalid", inst_valid, 1'b0);
        chk("fetch_inst_nop", inst, NOP_INST);
        for (int i = 0; i < nwait; i++) begin
            imem_ack = 1'b0;
            commit = spur;
            step();
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_invalid", inst_valid, 1'b0);
        end
        commit = spur;
        imem_ack = 1'b1;
        imem_rdata = v.rdata;
        step();
        commit = 1'b0;
        imem_ack = spur;
        imem_rdata = ~v.rdata;
        chk("issue_valid", inst_valid, 1'b1);
        chk("issue_inst", inst, v.rdata);
        chk("issue_pc", pc, exp_pc);
        chk("issue_pc4", pc4, exp_pc + 32'd4);
        chk("issue_req", imem_req, 1'b0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", inst_valid, 1'b1);
            chk("hold_inst", inst, v.rdata);
        end
        npc_op = v.op;
        br_taken = v.bt;
        imm = v.imm;
        rs1_data = v.rs1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        imem_ack = 1'b0;
        if (v.exp_npc[1:0] != 2'b00) begin
            chk("err_flag", fetch_err, 1'b1);
            chk("err_req", imem_req, 1'b0);
            chk("err_valid", inst_valid, 1'b0);
            chk("err_pc", pc, exp_pc);
        end else begin
            chk("next_req", imem_req, 1'b1);
            chk("next_addr", imem_addr, v.exp_npc);
            chk("next_invalid", inst_valid, 1'b0);
            chk("next_inst_nop", inst, NOP_INST);
            chk("next_err", fetch_err, 1'b0);
            exp_pc = v.exp_npc;
        end
    endtask

    initial begin
        vec_t v;
        logic [1:0]  r_op;
        logic        r_bt;
        logic [31:0] r_imm;
        logic [31:0] r_rs1;

        // {op, br_taken, imm, rs1, rdata, expected next pc}
        tbl[0]  = {2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0050_0093, 32'h0000_0004};
        tbl[1]  = {2'b11, 1'b0, 32'h0000_00FC, 32'h0, 32'h0FC0_006F, 32'h0000_0100};
        tbl[2]  = {2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFE00_08E3, 32'h0000_00F0};
        tbl[3]  = {2'b01, 1'b0, 32'h0000_0000, 32'h100, 32'h0000_8067, 32'h0000_0100};
        tbl[4]  = {2'b00, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hFE00_08E3, 32'h0000_0104};
        tbl[5]  = {2'b11, 1'b0, 32'hFFFF_FFEC, 32'h0, 32'hFEDF_F06F, 32'h0000_00F0};
        tbl[6]  = {2'b01, 1'b0, 32'h0000_0000, 32'h201, 32'h0000_8067, 32'h0000_0200};
        tbl[7]  = {2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0013, 32'h0000_0204};
        tbl[8]  = {2'b01, 1'b0, 32'h0000_0004, 32'hFFFF_FFF8, 32'h0040_8067, 32'hFFFF_FFFC};
        tbl[9]  = {2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0013, 32'h0000_0000};
        tbl[10] = {2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h1000_006F, 32'h0000_0100};
        tbl[11] = {2'b11, 1'b0, 32'h0000_0002, 32'h0, 32'h0020_006F, 32'h0000_0102};

        do_reset();
        step();
        chk("boot_req", imem_req, 1'b1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_inst", inst, NOP_INST);
        chk("boot_valid", inst_valid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            if (i == 9) chk("wrap_pc4", pc4 === 32'h0 || !inst_valid, 1'b1);
            instr(tbl[i], (i == 0) ? 3 : i % 3, i % 2, i[0]);
        end

        // Error state must persist regardless of ack/commit activity
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            commit = 1'b1;
            npc_op = 2'b10;
            step();
            chk("err_sticky", fetch_err, 1'b1);
            chk("err_noreq", imem_req, 1'b0);
            chk("err_pc_hold", pc, 32'h0000_0100);
        end
        imem_ack = 1'b0;
        commit = 1'b0;

        // Reset asserted mid-fetch drops imem_req without a clock edge
        do_reset();
        step();
        chk("mf_req", imem_req, 1'b1);
        imem_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mf_async_req", imem_req, 1'b0);
        step();
        rst_n = 1'b1;
        imem_ack = 1'b0;
        step();
        chk("mf_restart_req", imem_req, 1'b1);
        chk("mf_restart_addr", imem_addr, RESET_PC);
        chk("mf_restart_valid", inst_valid, 1'b0);

        exp_pc = RESET_PC;
        for (int k = 0; k < 250; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_bt = 1'($urandom_range(0, 1));
            r_imm = $urandom;
            if ($urandom_range(0, 15) != 0) r_imm[1:0] = 2'b00;
            r_rs1 = $urandom;
            r_rs1[1] = ($urandom_range(0, 15) == 0);
            v.op = r_op;
            v.bt = r_bt;
            v.imm = r_imm;
            v.rs1 = r_rs1;
            v.rdata = $urandom;
            v.exp_npc = ref_npc(r_op, r_bt, exp_pc, r_imm, r_rs1);
            instr(v, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if (v.exp_npc[1:0] != 2'b00) begin
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
